aoi222_bist_ctrl: RTL and testbench

- Built-in self-test controller for one 6-input AOI222 cell instance: ZN = ~((A1&A2)|(B1&B2)|(C1&C2)).
- Drives A1..C2 of the cell under test and reads back its ZN.
- Applies all 64 input combinations, compares each against a golden model, and counts mismatches.
- Sits beside library cells on test-chip characterization tiles; the tile's test sequencer controls it through a start/done pair.

---
 rtl/aoi222_bist_pkg.sv | 24 ++
 rtl/aoi222_bist_golden.sv | 19 +
 rtl/aoi222_bist_ctrl.sv | 179 +++++++++++++++++
 tb/tb_aoi222_bist_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aoi222_bist_pkg.sv
// Shared types and constants for the AOI222 self-test controller.
// Vector bit order on the cell pins is A1,A2,B1,B2,C1,C2 from the LSB upward.
package aoi222_bist_pkg;

  localparam int VEC_W   = 6;
  localparam int NUM_VEC = 64;

  localparam int PIN_A1 = 0;
  localparam int PIN_A2 = 1;
  localparam int PIN_B1 = 2;
  localparam int PIN_B2 = 3;
  localparam int PIN_C1 = 4;
  localparam int PIN_C2 = 5;

  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/aoi222_bist_golden.sv
// Golden model of the AOI222 cell: ZN = ~((A1&A2)|(B1&B2)|(C1&C2)).
// Purely combinational; maps a packed stimulus vector to the expected ZN.
module aoi222_bist_golden
  import aoi222_bist_pkg::*;
(
  input  logic [VEC_W-1:0] vec_i,
  output logic             zn_o
);

  logic pair_a;
  logic pair_b;
  logic pair_c;

  assign pair_a = vec_i[PIN_A1] & vec_i[PIN_A2];
  assign pair_b = vec_i[PIN_B1] & vec_i[PIN_B2];
  assign pair_c = vec_i[PIN_C1] & vec_i[PIN_C2];
  assign zn_o   = ~(pair_a | pair_b | pair_c);

endmodule

// File: rtl/aoi222_bist_ctrl.sv
// Exhaustive self-test of one AOI222 cell: sweeps all 64 input vectors, holds each for
// SETTLE_CYCLES, compares ZN with the golden model and counts mismatches (saturating).
// Optional first-failure log enabled by defining AOI222_BIST_FAIL_LOG_EN.
module aoi222_bist_ctrl
  import aoi222_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 7
)
(
  input  logic             CLK,
  input  logic             RN,
  input  logic             start,
  input  logic             zn_obs,
  output logic             A1,
  output logic             A2,
  output logic             B1,
  output logic             B2,
  output logic             C1,
  output logic             C2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
`ifdef AOI222_BIST_FAIL_LOG_EN
  output logic [5:0]       first_fail,
  output logic [0:0]       first_fail_vld,
`endif
  output state_e           state_dbg
);

  // Handshake: start is a one-cycle request sampled on CLK; it is accepted only in
  // IDLE or DONE. busy is high from the accepting edge until done rises; done stays
  // high (with pass valid) until the next accepted start.

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [3:0]       settle_q, settle_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic             zn_exp;
  logic             mismatch;
  logic             accept;
  logic             check_fire;
  logic [ERR_W-1:0] err_chk;

  aoi222_bist_golden u_golden (
    .vec_i (vec_q),
    .zn_o  (zn_exp)
  );

  // Anything other than a clean 0/1 on zn_obs falls into the default arm as a mismatch.
  always_comb begin
    mismatch = 1'b1;
    case (zn_obs)
      1'b0:    mismatch = zn_exp;
      1'b1:    mismatch = ~zn_exp;
      default: mismatch = 1'b1;
    endcase
  end

  assign accept     = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign check_fire = (state_q == ST_CHECK);
  assign err_chk    = (mismatch && (err_q != '1)) ? err_q + ERR_W'(1) : err_q;

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    err_d    = err_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_d  = ST_SETTLE;
          vec_d    = '0;
          settle_d = '0;
          err_d    = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
        end
      end
      ST_SETTLE: begin
        settle_d = settle_q + 4'd1;
        if (settle_q == SETTLE_LAST) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        err_d = err_chk;
        if (vec_q == LAST_VEC) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_chk == '0);
        end else begin
          state_d  = ST_SETTLE;
          vec_d    = vec_q + VEC_W'(1);
          settle_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q  <= ST_IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      err_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

`ifdef AOI222_BIST_FAIL_LOG_EN
  logic [VEC_W-1:0] ff_q, ff_d;
  logic             ff_vld_q, ff_vld_d;

  always_comb begin
    ff_d     = ff_q;
    ff_vld_d = ff_vld_q;
    if (accept) begin
      ff_d     = '0;
      ff_vld_d = 1'b0;
    end else if (check_fire && mismatch && !ff_vld_q) begin
      ff_d     = vec_q;
      ff_vld_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      ff_q     <= '0;
      ff_vld_q <= 1'b0;
    end else begin
      ff_q     <= ff_d;
      ff_vld_q <= ff_vld_d;
    end
  end

  assign first_fail        = ff_q;
  assign first_fail_vld[0] = ff_vld_q;
`else
  logic unused_check_fire;
  assign unused_check_fire = check_fire;
`endif

  assign A1        = vec_q[PIN_A1];
  assign A2        = vec_q[PIN_A2];
  assign B1        = vec_q[PIN_B1];
  assign B2        = vec_q[PIN_B2];
  assign C1        = vec_q[PIN_C1];
  assign C2        = vec_q[PIN_C2];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_aoi222_bist_ctrl.sv
// Directed testbench for aoi222_bist_ctrl: default instance plus a SETTLE_CYCLES=1,
// ERR_W=4 instance. Fail-log checks compile in when AOI222_BIST_FAIL_LOG_EN is defined.
module tb_aoi222_bist_ctrl;
  import aoi222_bist_pkg::*;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RN  = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- DUT 0: default parameters ----------------
  logic       start0 = 1'b0;
  int         mode0  = 0;  // 0 ideal, 1 stuck-at-0, 2 stuck-at-1
  logic       zn0;
  logic       a1_0, a2_0, b1_0, b2_0, c1_0, c2_0;
  logic       busy0, done0, pass0;
  logic [6:0] err0;
  state_e     st0;
  logic       zn_ideal0;
`ifdef AOI222_BIST_FAIL_LOG_EN
  logic [5:0] ff0;
  logic [0:0] ffv0;
`endif

  assign zn_ideal0 = ~((a1_0 & a2_0) | (b1_0 & b2_0) | (c1_0 & c2_0));
  assign zn0 = (mode0 == 1) ? 1'b0 : (mode0 == 2) ? 1'b1 : zn_ideal0;

  aoi222_bist_ctrl u_dut0 (
    .CLK (CLK), .RN (RN), .start (start0), .zn_obs (zn0),
    .A1 (a1_0), .A2 (a2_0), .B1 (b1_0), .B2 (b2_0), .C1 (c1_0), .C2 (c2_0),
    .busy (busy0), .done (done0), .pass (pass0), .err_count (err0),
`ifdef AOI222_BIST_FAIL_LOG_EN
    .first_fail (ff0), .first_fail_vld (ffv0),
`endif
    .state_dbg (st0)
  );

  // ---------------- DUT 1: SETTLE_CYCLES=1, ERR_W=4 ----------------
  logic       start1 = 1'b0;
  int         mode1  = 0;  // 0 ideal delayed by one cycle, 2 stuck-at-1
  logic       zn1;
  logic       a1_1, a2_1, b1_1, b2_1, c1_1, c2_1;
  logic       busy1, done1, pass1;
  logic [3:0] err1;
  state_e     st1;
  logic       zn_dly1 = 1'b1;
`ifdef AOI222_BIST_FAIL_LOG_EN
  logic [5:0] ff1;
  logic [0:0] ffv1;
`endif

  always @(posedge CLK) zn_dly1 <= ~((a1_1 & a2_1) | (b1_1 & b2_1) | (c1_1 & c2_1));
  assign zn1 = (mode1 == 2) ? 1'b1 : zn_dly1;

  aoi222_bist_ctrl #(.SETTLE_CYCLES(1), .ERR_W(4)) u_dut1 (
    .CLK (CLK), .RN (RN), .start (start1), .zn_obs (zn1),
    .A1 (a1_1), .A2 (a2_1), .B1 (b1_1), .B2 (b2_1), .C1 (c1_1), .C2 (c2_1),
    .busy (busy1), .done (done1), .pass (pass1), .err_count (err1),
`ifdef AOI222_BIST_FAIL_LOG_EN
    .first_fail (ff1), .first_fail_vld (ffv1),
`endif
    .state_dbg (st1)
  );

  // ---------------- golden model under direct test ----------------
  logic [5:0] gv = '0;
  logic       gz;
  logic       exp_q[$];

  aoi222_bist_golden u_gold (.vec_i (gv), .zn_o (gz));

  // ---------------- driver tasks ----------------
  task automatic run0(input int restart_at, output int cycles);
    cycles = -1;
    @(negedge CLK);
    start0 = 1'b1;
    @(posedge CLK);
    #1;
    start0 = 1'b0;
    checks++;
    if (busy0 !== 1'b1 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL run0_accept busy=%b done=%b required busy=1 done=0", busy0, done0);
    end
    for (int n = 1; n <= 1000 && cycles < 0; n++) begin
      @(posedge CLK);
      #1;
      if (done0 === 1'b1) cycles = n;
      start0 = (n == restart_at);
    end
    start0 = 1'b0;
  endtask

  task automatic run1(output int cycles);
    cycles = -1;
    @(negedge CLK);
    start1 = 1'b1;
    @(posedge CLK);
    #1;
    start1 = 1'b0;
    for (int n = 1; n <= 1000 && cycles < 0; n++) begin
      @(posedge CLK);
      #1;
      if (done1 === 1'b1) cycles = n;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({c2_0, c1_0, b2_0, b1_0, a2_0, a1_0} !== 6'h00 || busy0 !== 1'b0 || done0 !== 1'b0
        || pass0 !== 1'b0 || err0 !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs pins=%h busy=%b done=%b pass=%b err=%0d required all 0",
               {c2_0, c1_0, b2_0, b1_0, a2_0, a1_0}, busy0, done0, pass0, err0);
    end
    checks++;
    if (st0 !== ST_IDLE || err1 !== 4'd0) begin
      errors++;
      $display("FAIL reset_state st0=%0d err1=%0d required st0=0 err1=0", st0, err1);
    end
`ifdef AOI222_BIST_FAIL_LOG_EN
    checks++;
    if (ffv0 !== 1'b0 || ff0 !== 6'd0) begin
      errors++;
      $display("FAIL reset_fail_log vld=%b ff=%0d required 0 0", ffv0, ff0);
    end
`endif
    @(negedge CLK);
    RN = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (st0 !== ST_IDLE || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold st0=%0d busy=%b required st0=0 busy=0", st0, busy0);
    end
  endtask

  task automatic test_golden();
    for (int v = 0; v < 64; v++) begin
      logic [5:0] b;
      b = 6'(v);
      exp_q.push_back(~((b[0] & b[1]) | (b[2] & b[3]) | (b[4] & b[5])));
    end
    for (int v = 0; v < 64; v++) begin
      logic e;
      gv = 6'(v);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (gz !== e) begin
        errors++;
        $display("FAIL golden vec=%0d got=%b required=%b", v, gz, e);
      end
    end
  endtask

  task automatic test_ideal();
    int cyc;
    mode0 = 0;
    run0(0, cyc);
    checks++;
    if (cyc != 192) begin
      errors++;
      $display("FAIL ideal_latency cycles=%0d required 192", cyc);
    end
    checks++;
    if (err0 !== 7'd0 || pass0 !== 1'b1 || busy0 !== 1'b0 || st0 !== ST_DONE) begin
      errors++;
      $display("FAIL ideal_result err=%0d pass=%b busy=%b st=%0d required 0 1 0 3",
               err0, pass0, busy0, st0);
    end
    checks++;
    if ({c2_0, c1_0, b2_0, b1_0, a2_0, a1_0} !== 6'h3f) begin
      errors++;
      $display("FAIL ideal_pins pins=%h required 3f", {c2_0, c1_0, b2_0, b1_0, a2_0, a1_0});
    end
  endtask

  task automatic test_stuck(input int mode, input logic [6:0] exp_err, input logic [5:0] exp_ff);
    int cyc;
    mode0 = mode;
    run0(0, cyc);
    mode0 = 0;
    checks++;
    if (cyc != 192 || err0 !== exp_err || pass0 !== 1'b0) begin
      errors++;
      $display("FAIL stuck%0d cycles=%0d err=%0d pass=%b required 192 %0d 0",
               mode - 1, cyc, err0, pass0, exp_err);
    end
`ifdef AOI222_BIST_FAIL_LOG_EN
    checks++;
    if (ffv0 !== 1'b1 || ff0 !== exp_ff) begin
      errors++;
      $display("FAIL stuck%0d_first_fail vld=%b ff=%0d required 1 %0d", mode - 1, ffv0, ff0, exp_ff);
    end
`else
    if (exp_ff > 6'd63) $display("unreachable");
`endif
  endtask

  task automatic test_restart_ignored();
    int cyc;
    mode0 = 0;
    run0(50, cyc);
    checks++;
    if (cyc != 192 || err0 !== 7'd0 || pass0 !== 1'b1) begin
      errors++;
      $display("FAIL restart_ignored cycles=%0d err=%0d pass=%b required 192 0 1", cyc, err0, pass0);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    mode0 = 1;
    @(negedge CLK);
    start0 = 1'b1;
    @(posedge CLK);
    #1;
    start0 = 1'b0;
    repeat (100) @(posedge CLK);
    #1;
    RN = 1'b0;
    #1;
    checks++;
    if ({c2_0, c1_0, b2_0, b1_0, a2_0, a1_0} !== 6'h00 || busy0 !== 1'b0 || done0 !== 1'b0
        || pass0 !== 1'b0 || err0 !== 7'd0 || st0 !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_mid_outputs pins=%h busy=%b done=%b pass=%b err=%0d st=%0d required all 0",
               {c2_0, c1_0, b2_0, b1_0, a2_0, a1_0}, busy0, done0, pass0, err0, st0);
    end
    mode0 = 0;
    @(negedge CLK);
    RN = 1'b1;
    run0(0, cyc);
    checks++;
    if (cyc != 192 || err0 !== 7'd0 || pass0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_rerun cycles=%0d err=%0d pass=%b required 192 0 1", cyc, err0, pass0);
    end
  endtask

  task automatic test_settle1_delayed();
    int cyc;
    mode1 = 0;
    run1(cyc);
    checks++;
    if (cyc != 128 || err1 !== 4'd0 || pass1 !== 1'b1) begin
      errors++;
      $display("FAIL settle1_delayed cycles=%0d err=%0d pass=%b required 128 0 1", cyc, err1, pass1);
    end
  endtask

  task automatic test_saturate();
    int cyc;
    mode1 = 2;
    run1(cyc);
    mode1 = 0;
    checks++;
    if (cyc != 128 || err1 !== 4'd15 || pass1 !== 1'b0) begin
      errors++;
      $display("FAIL saturate cycles=%0d err=%0d pass=%b required 128 15 0", cyc, err1, pass1);
    end
`ifdef AOI222_BIST_FAIL_LOG_EN
    checks++;
    if (ffv1 !== 1'b1 || ff1 !== 6'd3) begin
      errors++;
      $display("FAIL saturate_first_fail vld=%b ff=%0d required 1 3", ffv1, ff1);
    end
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_golden();
    test_ideal();
    test_stuck(1, 7'd27, 6'd0);
    test_stuck(2, 7'd37, 6'd3);
    test_ideal();
    test_restart_ignored();
    test_reset_mid_run();
    test_settle1_delayed();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
